// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   Elastic buffer between an ALU result stage and its downstream consumer.
//   Each entry holds {cout, z}. Strict FIFO order, DEPTH entries, with a
//   pushin/stopin handshake upstream and a pushout/stopout handshake downstream.
//   stopin, pushout, z and cout come straight from registers. There is no
//   combinational path from pushin or stopout to any output, and an entry
//   written into an empty FIFO first appears one cycle later.
//
// Parameters
//   W        result data width (matches ALU z)
//   DEPTH    entry count, power of two, >= 2
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   pushin   upstream result valid
//   z_in     upstream result data
//   cout_in  upstream carry-out
//   stopin   FIFO full; upstream must hold off
//   pushout  head entry valid
//   z        head entry data (0 while empty)
//   cout     head entry carry (0 while empty)
//   stopout  downstream refuses the current head
//   count    number of occupied entries
//   drop_cnt saturating count of pushes refused while full
//            (only present when ALU_RESULT_FIFO_DROP_CNT_EN is defined)
//
// Optional feature macro: ALU_RESULT_FIFO_DROP_CNT_EN
// -----------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pushin,
   input  logic [W-1:0]            z_in,
   input  logic                    cout_in,
   output logic                    stopin,
   output logic                    pushout,
   output logic [W-1:0]            z,
   output logic                    cout,
   input  logic                    stopout,
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   output logic [15:0]             drop_cnt,
`endif
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   C_CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

   logic [W:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_nempty;
   logic [W:0]    r_head;

   logic          w_push;
   logic          w_pop;
   logic [W:0]    w_in_word;
   logic [AW-1:0] w_rd_ptr_inc;
   logic [AW:0]   w_count_nxt;
   logic [W:0]    w_head_nxt;

   // Transfer qualification, next occupancy and next registered head entry.
   always_comb begin
      w_in_word    = {cout_in, z_in};
      w_push       = pushin & ~r_full;
      w_pop        = r_nempty & ~stopout;
      w_rd_ptr_inc = r_rd_ptr + C_PTR_ONE;
      w_count_nxt  = r_count;
      w_head_nxt   = r_head;

      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase

      // The head is kept in its own register so z/cout are flop outputs.
      // After a pop the new head is the next stored entry, except when the
      // FIFO held a single entry: then it is the word being pushed in the
      // same cycle (not yet in r_mem), or nothing at all.
      if (w_pop) begin
         if (w_count_nxt == C_CNT_ZERO) begin
            w_head_nxt = {(W+1){1'b0}};
         end else if (r_count == C_CNT_ONE) begin
            w_head_nxt = w_in_word;
         end else begin
            w_head_nxt = r_mem[w_rd_ptr_inc];
         end
      end else if (!r_nempty && w_push) begin
         w_head_nxt = w_in_word;
      end else begin
         w_head_nxt = r_head;
      end
   end

   // Pointers, occupancy, status flags and head register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= C_PTR_ZERO;
         r_rd_ptr <= C_PTR_ZERO;
         r_count  <= C_CNT_ZERO;
         r_full   <= 1'b0;
         r_nempty <= 1'b0;
         r_head   <= {(W+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == C_CNT_FULL);
         r_nempty <= (w_count_nxt != C_CNT_ZERO);
         r_head   <= w_head_nxt;
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= w_in_word;
      end
   end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   logic        w_drop;
   logic [15:0] r_drop_cnt;

   assign w_drop = pushin & r_full;

   // Saturating count of pushes refused while full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= 16'h0000;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'h0001;
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign stopin  = r_full;
   assign pushout = r_nempty;
   assign z       = r_head[W-1:0];
   assign cout    = r_head[W];
   assign count   = r_count;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

   logic        clk;
   logic        rst;
   logic        pushin;
   logic [31:0] z_in;
   logic        cout_in;
   logic        stopin;
   logic        pushout;
   logic [31:0] z;
   logic        cout;
   logic        stopout;
   logic [2:0]  count;
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   alu_result_fifo #(.W(32), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .pushin   (pushin),
      .z_in     (z_in),
      .cout_in  (cout_in),
      .stopin   (stopin),
      .pushout  (pushout),
      .z        (z),
      .cout     (cout),
      .stopout  (stopout),
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      .drop_cnt (drop_cnt),
`endif
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hard time bound in case the clock ever stops.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; pushin = 1'b0; z_in = 32'h0; cout_in = 1'b0; stopout = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_count",   64'(count),   64'd0);
      chk("rst_pushout", 64'(pushout), 64'd0);
      chk("rst_stopin",  64'(stopin),  64'd0);
      chk("rst_z",       64'(z),       64'd0);
      chk("rst_cout",    64'(cout),    64'd0);
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif

      // Basic latency: push while empty, visible next cycle, popped after.
      pushin = 1'b1; z_in = 32'h0000_00A5; cout_in = 1'b1;
      tick();
      pushin = 1'b0; cout_in = 1'b0;
      chk("lat_pushout", 64'(pushout), 64'd1);
      chk("lat_z",       64'(z),       64'h0000_00A5);
      chk("lat_cout",    64'(cout),    64'd1);
      chk("lat_count",   64'(count),   64'd1);
      tick();
      chk("lat_count0",   64'(count),   64'd0);
      chk("lat_pushout0", 64'(pushout), 64'd0);
      chk("lat_z0",       64'(z),       64'd0);
      chk("lat_cout0",    64'(cout),    64'd0);

      // Fill to FULL under back-pressure, then drain in order.
      stopout = 1'b1; pushin = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         z_in = 32'(i);
         tick();
      end
      pushin = 1'b0;
      chk("fill_count",  64'(count),  64'd4);
      chk("fill_stopin", 64'(stopin), 64'd1);
      chk("fill_head",   64'(z),      64'd1);
      stopout = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_pushout", 64'(pushout), 64'd1);
         chk("drain_z",       64'(z),       64'(i));
         tick();
      end
      chk("drain_empty", 64'(pushout), 64'd0);
      chk("drain_count", 64'(count),   64'd0);
      chk("drain_stopin", 64'(stopin), 64'd0);

      // Overflow: refused pushes while FULL leave contents untouched.
      stopout = 1'b1; pushin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         z_in = 32'h100 + 32'(i);
         tick();
      end
      z_in = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ovf_count",  64'(count),  64'd4);
         chk("ovf_stopin", 64'(stopin), 64'd1);
         chk("ovf_head",   64'(z),      64'h100);
      end
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      chk("ovf_drop3", 64'(drop_cnt), 64'd3);
`endif
      // Push and pop together while FULL: only the pop happens.
      stopout = 1'b0;
      tick();
      pushin = 1'b0;
      chk("full_both_count", 64'(count), 64'd3);
      chk("full_both_head",  64'(z),     64'h101);
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      chk("ovf_drop4", 64'(drop_cnt), 64'd4);
`endif
      for (int i = 1; i < 4; i++) begin
         chk("ovf_drain_z", 64'(z), 64'h100 + 64'(i));
         tick();
      end
      chk("ovf_drain_empty", 64'(pushout), 64'd0);

      // Steady stream: two preloaded entries, then push/pop every cycle.
      stopout = 1'b1; pushin = 1'b1;
      z_in = 32'd8; tick();
      z_in = 32'd9; tick();
      stopout = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("stream_head", 64'(z), 64'(8 + i));
         z_in = 32'(10 + i);
         tick();
         chk("stream_count", 64'(count), 64'd2);
      end
      pushin = 1'b0;
      chk("stream_tail0", 64'(z), 64'd18);
      tick();
      chk("stream_tail1", 64'(z), 64'd19);
      tick();
      chk("stream_empty", 64'(pushout), 64'd0);

      // Back-pressure stability of the head entry.
      stopout = 1'b1; pushin = 1'b1;
      z_in = 32'h1234_5678; tick();
      z_in = 32'hAAAA_0000; tick();
      pushin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_z",       64'(z),       64'h1234_5678);
         chk("bp_pushout", 64'(pushout), 64'd1);
      end
      chk("bp_count", 64'(count), 64'd2);

      // Reset with data held: everything discarded, no transfer.
      pushin = 1'b1; z_in = 32'h0000_0777; tick();
      chk("pre_rst_count", 64'(count), 64'd3);
      rst = 1'b1; stopout = 1'b0; z_in = 32'h0000_0888;
      tick();
      rst = 1'b0; pushin = 1'b0;
      chk("mid_rst_count",   64'(count),   64'd0);
      chk("mid_rst_pushout", 64'(pushout), 64'd0);
      chk("mid_rst_z",       64'(z),       64'd0);
      chk("mid_rst_stopin",  64'(stopin),  64'd0);
      tick();
      chk("post_rst_pushout", 64'(pushout), 64'd0);
      chk("post_rst_count",   64'(count),   64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
